// File: rtl/chan_mux.sv
// chan_mux: fixed-select / round-robin N:1 channel mux feeding one registered output stage.
module chan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);
    logic [WIDTH-1:0] ch_data [CHANNELS];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d, rr_ptr_q, rr_ptr_d, rr_idx, gnt_idx;
    logic             out_valid_q, out_valid_d, rr_hit, gnt_valid, accept;
    logic [SEL_W:0]   cand;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Farthest candidates are visited first so the nearest valid one after rr_ptr wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = rr_ptr_q;
        cand   = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            cand = (cand >= (SEL_W+1)'(CHANNELS)) ? cand - (SEL_W+1)'(CHANNELS) : cand;
            if (in_valid[cand[SEL_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_valid   = mode ? rr_hit : (({1'b0, sel} < (SEL_W+1)'(CHANNELS)) && in_valid[sel]);
        gnt_idx     = mode ? rr_idx : sel;
        accept      = rst_n && gnt_valid && (!out_valid_q || out_ready);
        in_ready    = accept ? CHANNELS'(1) << gnt_idx : '0;
        rr_ptr_d    = accept ? gnt_idx : rr_ptr_q;
        out_valid_d = accept || (out_valid_q && !out_ready);
        out_data_d  = accept ? ch_data[gnt_idx] : out_data_q;
        out_chan_d  = accept ? gnt_idx : out_chan_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(CHANNELS-1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_chan_mux.sv
// tb_chan_mux: directed and randomized checks of chan_mux against a behavioural model.
module tb_chan_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_valid = '0;
    logic [7:0]  in_ready;
    logic        mode = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  sel = '0;
    logic [2:0]  out_chan;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [39:0] in_data5 = '0;
    logic [4:0]  in_valid5 = '0;
    logic [4:0]  in_ready5;
    logic        mode5 = 1'b0;
    logic        out_ready5 = 1'b0;
    logic        out_valid5;
    logic [2:0]  sel5 = '0;
    logic [2:0]  out_chan5;
    logic [7:0]  out_data5;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_data = '0;
    int          m_chan = 0;
    int          m_rr = 7;
    int          g;
    logic        acc;
    logic [7:0]  exp_ready;

    always #5 clk = ~clk;

    chan_mux u8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    chan_mux #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) u5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .mode(mode5), .sel(sel5), .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
        .out_ready(out_ready5)
    );

    function automatic int pick(input logic md, input logic [2:0] s, input logic [7:0] v,
                                input int rr, input int n);
        if (!md) return (int'(s) < n && v[s]) ? int'(s) : -1;
        for (int k = 1; k <= n; k++) if (v[3'((rr + k) % n)]) return (rr + k) % n;
        return -1;
    endfunction

    always_comb begin
        g         = pick(mode, sel, in_valid, m_rr, 8);
        acc       = rst_n && (!m_valid || out_ready) && g >= 0;
        exp_ready = acc ? 8'(1 << g) : 8'h00;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= 0;
            m_rr    <= 7;
        end else if (acc) begin
            m_valid <= 1'b1;
            m_data  <= in_data[g*8 +: 8];
            m_chan  <= g;
            m_rr    <= g;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk("model in_ready", 64'(in_ready), 64'(exp_ready));
        chk("model out_valid", 64'(out_valid), 64'(m_valid));
        chk("model out_data", 64'(out_data), 64'(m_data));
        chk("model out_chan", 64'(out_chan), 64'(m_chan));
    end

    initial begin
        mode = 1'b1;
        in_valid = 8'hFF;
        in_data = 64'h7766A5443C221100;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'h0);
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset out_data", 64'(out_data), 64'h0);
        chk("reset out_chan", 64'(out_chan), 64'h0);
        rst_n = 1'b1;
        mode = 1'b0;
        sel = 3'd5;
        out_ready = 1'b1;
        #1;
        chk("fixed in_ready", 64'(in_ready), 64'h20);
        step;
        chk("fixed out_data", 64'(out_data), 64'hA5);
        chk("fixed out_chan", 64'(out_chan), 64'h5);
        chk("fixed out_valid", 64'(out_valid), 64'h1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step;
            chk("rr seq out_chan", 64'(out_chan), 64'(i % 8));
            chk("rr seq out_valid", 64'(out_valid), 64'h1);
        end
        in_valid = 8'h08;
        step;
        chk("bp capture data", 64'(out_data), 64'h3C);
        out_ready = 1'b0;
        in_valid = 8'h48;
        #1;
        chk("bp in_ready", 64'(in_ready), 64'h0);
        repeat (4) begin
            step;
            chk("bp hold data", 64'(out_data), 64'h3C);
            chk("bp hold valid", 64'(out_valid), 64'h1);
            chk("bp hold in_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 64'(in_ready), 64'h40);
        step;
        chk("bp release data", 64'(out_data), 64'h66);
        chk("bp release chan", 64'(out_chan), 64'h6);
        in_valid = 8'h05;
        #1;
        chk("wrap in_ready", 64'(in_ready), 64'h01);
        step;
        chk("wrap chan a", 64'(out_chan), 64'h0);
        step;
        chk("wrap chan b", 64'(out_chan), 64'h2);
        step;
        chk("wrap chan c", 64'(out_chan), 64'h0);
        in_valid = 8'h10;
        step;
        out_ready = 1'b0;
        in_valid = 8'h00;
        step;
        chk("pre-reset valid", 64'(out_valid), 64'h1);
        chk("pre-reset data", 64'(out_data), 64'h44);
        in_valid = 8'hFF;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 64'(out_valid), 64'h0);
        chk("async rst data", 64'(out_data), 64'h0);
        chk("async rst in_ready", 64'(in_ready), 64'h0);
        #1;
        rst_n = 1'b1;
        in_valid = 8'h00;
        out_ready = 1'b1;
        step;
        chk("post-rst no word", 64'(out_valid), 64'h0);
        in_valid = 8'h81;
        step;
        chk("post-rst first chan", 64'(out_chan), 64'h0);
        chk("post-rst first valid", 64'(out_valid), 64'h1);
        step;
        chk("post-rst second data", 64'(out_data), 64'h77);
        in_valid = 8'h00;
        in_data5 = 40'h4433221100;
        sel5 = 3'd6;
        in_valid5 = 5'h1F;
        out_ready5 = 1'b1;
        #1;
        chk("ch5 sel6 in_ready", 64'(in_ready5), 64'h0);
        step;
        chk("ch5 sel6 valid a", 64'(out_valid5), 64'h0);
        step;
        chk("ch5 sel6 valid b", 64'(out_valid5), 64'h0);
        sel5 = 3'd2;
        #1;
        chk("ch5 sel2 in_ready", 64'(in_ready5), 64'h04);
        step;
        chk("ch5 sel2 chan", 64'(out_chan5), 64'h2);
        chk("ch5 sel2 data", 64'(out_data5), 64'h22);
        chk("ch5 sel2 valid", 64'(out_valid5), 64'h1);
        repeat (3000) begin
            step;
            mode = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            in_valid = $urandom_range(0, 1) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            in_data = {$urandom, $urandom};
            out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
